// File: rtl/aemb2_mul_sched_if.sv
// rtl/aemb2_mul_sched_if.sv - requester, multiplier and result bundle for the shared multiplier scheduler
interface aemb2_mul_sched_if #(
  parameter int TAGW = 5
);
  logic            dena;
  logic            req0_vld;
  logic            req0_rdy;
  logic [31:0]     req0_opa;
  logic [31:0]     req0_opb;
  logic [TAGW-1:0] req0_tag;
  logic            req1_vld;
  logic            req1_rdy;
  logic [31:0]     req1_opa;
  logic [31:0]     req1_opb;
  logic [TAGW-1:0] req1_tag;
  logic            flush0;
  logic            flush1;
  logic [31:0]     mul_opa;
  logic [31:0]     mul_opb;
  logic [31:0]     mul_mx;
  logic            res0_vld;
  logic [31:0]     res0_dat;
  logic [TAGW-1:0] res0_tag;
  logic            res1_vld;
  logic [31:0]     res1_dat;
  logic [TAGW-1:0] res1_tag;

  modport slave (
    input  dena,
    input  req0_vld, req0_opa, req0_opb, req0_tag,
    input  req1_vld, req1_opa, req1_opb, req1_tag,
    input  flush0, flush1,
    input  mul_mx,
    output req0_rdy, req1_rdy,
    output mul_opa, mul_opb,
    output res0_vld, res0_dat, res0_tag,
    output res1_vld, res1_dat, res1_tag
  );

  modport master (
    output dena,
    output req0_vld, req0_opa, req0_opb, req0_tag,
    output req1_vld, req1_opa, req1_opb, req1_tag,
    output flush0, flush1,
    output mul_mx,
    input  req0_rdy, req1_rdy,
    input  mul_opa, mul_opb,
    input  res0_vld, res0_dat, res0_tag,
    input  res1_vld, res1_dat, res1_tag
  );
endinterface

// File: rtl/aemb2_mul_sched.sv
// rtl/aemb2_mul_sched.sv - round-robin issue scheduler for the shared two-thread multiplier
// Owner/tag pipeline shadows the multiplier so results return to the issuing thread.
module aemb2_mul_sched #(
  parameter int LAT  = 2,
  parameter int TAGW = 5
) (
  input  logic                gclk,
  input  logic                grst,
  aemb2_mul_sched_if.slave    bus
);
  localparam int LAST = LAT - 1;

  logic            elig0;
  logic            elig1;
  logic            gnt0;
  logic            gnt1;
  logic            win;

  logic            prio_q;
  logic            prio_d;
  logic [LAT-1:0]  vld_q;
  logic [LAT-1:0]  vld_d;
  logic [LAT-1:0]  own_q;
  logic [LAT-1:0]  own_d;
  logic [TAGW-1:0] tag_q [LAT];
  logic [TAGW-1:0] tag_d [LAT];
  logic [LAT-1:0]  live;

  // Reset gates eligibility so no grant or operand leaks out while grst is high.
  always_comb begin
    elig0 = ~grst & bus.dena & bus.req0_vld & ~bus.flush0;
    elig1 = ~grst & bus.dena & bus.req1_vld & ~bus.flush1;
    gnt0  = elig0 & (~elig1 | ~prio_q);
    gnt1  = elig1 & (~elig0 |  prio_q);
    win   = gnt1;
  end

  assign bus.req0_rdy = gnt0;
  assign bus.req1_rdy = gnt1;

  always_comb begin
    bus.mul_opa = 32'd0;
    bus.mul_opb = 32'd0;
    if (gnt0) begin
      bus.mul_opa = bus.req0_opa;
      bus.mul_opb = bus.req0_opb;
    end else if (gnt1) begin
      bus.mul_opa = bus.req1_opa;
      bus.mul_opb = bus.req1_opb;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (elig0 && elig1) begin
      prio_d = ~prio_q;
    end
  end

  // Flush kills a thread's stages regardless of dena; the shift only happens on dena.
  always_comb begin
    for (int i = 0; i < LAT; i++) begin
      live[i] = vld_q[i] & ~(own_q[i] ? bus.flush1 : bus.flush0);
    end
    vld_d = live;
    own_d = own_q;
    for (int i = 0; i < LAT; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (bus.dena) begin
      vld_d[0] = gnt0 | gnt1;
      own_d[0] = win;
      tag_d[0] = win ? bus.req1_tag : bus.req0_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = live[i-1];
        own_d[i] = own_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      prio_q <= 1'b0;
      vld_q  <= '0;
      own_q  <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      prio_q <= prio_d;
      vld_q  <= vld_d;
      own_q  <= own_d;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign bus.res0_vld = bus.dena & vld_q[LAST] & ~own_q[LAST] & ~bus.flush0;
  assign bus.res1_vld = bus.dena & vld_q[LAST] &  own_q[LAST] & ~bus.flush1;
  assign bus.res0_dat = bus.mul_mx;
  assign bus.res1_dat = bus.mul_mx;
  assign bus.res0_tag = tag_q[LAST];
  assign bus.res1_tag = tag_q[LAST];
endmodule

// File: tb/tb_aemb2_mul_sched.sv
// tb/tb_aemb2_mul_sched.sv - bench for aemb2_mul_sched against an in-flight operation list model
module tb_aemb2_mul_sched;
  localparam int LAT  = 2;
  localparam int TAGW = 5;

  logic gclk = 1'b0;
  logic grst;
  always #5 gclk = ~gclk;

  aemb2_mul_sched_if #(.TAGW(TAGW)) bus ();
  aemb2_mul_sched #(.LAT(LAT), .TAGW(TAGW)) dut (.gclk(gclk), .grst(grst), .bus(bus));

  // Stand-in for aeMB2_mult: two dena-qualified stages.
  logic [31:0] m1;
  logic [31:0] m2;
  always_ff @(posedge gclk) begin
    if (bus.dena) begin
      m1 <= bus.mul_opa * bus.mul_opb;
      m2 <= m1;
    end
  end
  assign bus.mul_mx = m2;

  typedef struct {
    bit              own;
    logic [TAGW-1:0] tag;
    logic [31:0]     prod;
    int              age;
  } op_t;

  op_t inflight[$];
  int  prio;
  int  n_run;
  int  n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAGW-1:0] t);
    if (n == 0) begin
      bus.req0_vld = v; bus.req0_opa = a; bus.req0_opb = b; bus.req0_tag = t;
    end else begin
      bus.req1_vld = v; bus.req1_opa = a; bus.req1_opb = b; bus.req1_tag = t;
    end
  endtask

  task automatic idle();
    bus.dena = 1'b1;
    bus.flush0 = 1'b0;
    bus.flush1 = 1'b0;
    set_req(0, 0, 32'd0, 32'd0, '0);
    set_req(1, 0, 32'd0, 32'd0, '0);
  endtask

  // Called just after a negedge with inputs applied; checks, crosses one posedge, updates the model.
  task automatic tick();
    bit              d, f0, f1, e0, e1, xv0, xv1;
    int              w, hit;
    logic [31:0]     xa, xb, p;
    logic [TAGW-1:0] xt;
    op_t             nop;
    #1;
    d  = bus.dena;
    f0 = bus.flush0;
    f1 = bus.flush1;
    e0 = d && bus.req0_vld && !f0;
    e1 = d && bus.req1_vld && !f1;
    w  = -1;
    if (e0 && e1) w = prio;
    else if (e0)  w = 0;
    else if (e1)  w = 1;
    xa = (w == 0) ? bus.req0_opa : (w == 1) ? bus.req1_opa : 32'd0;
    xb = (w == 0) ? bus.req0_opb : (w == 1) ? bus.req1_opb : 32'd0;
    xt = (w == 1) ? bus.req1_tag : bus.req0_tag;
    chk("rdy0", bus.req0_rdy, w == 0);
    chk("rdy1", bus.req1_rdy, w == 1);
    chk("mul_opa", bus.mul_opa, xa);
    chk("mul_opb", bus.mul_opb, xb);
    hit = -1;
    foreach (inflight[i]) if (inflight[i].age == LAT) hit = i;
    xv0 = d && (hit >= 0) && (inflight[hit].own == 1'b0) && !f0;
    xv1 = d && (hit >= 0) && (inflight[hit].own == 1'b1) && !f1;
    chk("res0_vld", bus.res0_vld, xv0);
    chk("res1_vld", bus.res1_vld, xv1);
    if (xv0) begin
      chk("res0_dat", bus.res0_dat, inflight[hit].prod);
      chk("res0_tag", bus.res0_tag, inflight[hit].tag);
    end
    if (xv1) begin
      chk("res1_dat", bus.res1_dat, inflight[hit].prod);
      chk("res1_tag", bus.res1_tag, inflight[hit].tag);
    end
    @(posedge gclk);
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      if ((inflight[i].own == 1'b0 && f0) || (inflight[i].own == 1'b1 && f1)) inflight.delete(i);
    end
    if (d) begin
      foreach (inflight[i]) inflight[i].age++;
      while (inflight.size() > 0 && inflight[0].age > LAT) void'(inflight.pop_front());
      if (w >= 0) begin
        p = xa * xb;
        nop.own = (w == 1); nop.tag = xt; nop.prod = p; nop.age = 1;
        inflight.push_back(nop);
      end
      if (e0 && e1) prio = 1 - prio;
    end
    @(negedge gclk);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    prio = 0;
    grst = 1'b1;
    idle();
    set_req(0, 1, 32'd5, 32'd5, 5'd1);
    set_req(1, 1, 32'd9, 32'd9, 5'd2);
    repeat (2) @(negedge gclk);
    chk("rst_rdy0", bus.req0_rdy, 1'b0);
    chk("rst_rdy1", bus.req1_rdy, 1'b0);
    chk("rst_opa", bus.mul_opa, 32'd0);
    chk("rst_res0", bus.res0_vld, 1'b0);
    chk("rst_res1", bus.res1_vld, 1'b0);
    grst = 1'b0;
    idle();

    // single issue 7*6 tag 3
    set_req(0, 1, 32'd7, 32'd6, 5'd3);
    tick();
    idle();
    repeat (3) tick();

    // contention: alternating grants
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 32'd10 + i, 32'd3, 5'(i));
      set_req(1, 1, 32'd20 + i, 32'd4, 5'(16 + i));
      tick();
    end
    idle();
    repeat (3) tick();

    // wrap and stall
    set_req(1, 1, 32'hFFFF_FFFF, 32'd2, 5'd9);
    tick();
    set_req(0, 1, 32'd3, 32'd3, 5'd4);
    set_req(1, 1, 32'd3, 32'd3, 5'd5);
    bus.dena = 1'b0;
    repeat (3) tick();
    idle();
    repeat (3) tick();

    // flush of requester 0
    set_req(0, 1, 32'd2, 32'd3, 5'd11); tick(); idle();
    set_req(1, 1, 32'd4, 32'd5, 5'd12); tick(); idle();
    set_req(0, 1, 32'd6, 32'd7, 5'd13); tick(); idle();
    set_req(0, 1, 32'd8, 32'd9, 5'd14);
    bus.flush0 = 1'b1;
    tick();
    idle();
    repeat (3) tick();

    // reset with work in flight
    set_req(0, 1, 32'd11, 32'd12, 5'd1); tick();
    set_req(1, 1, 32'd13, 32'd14, 5'd2); set_req(0, 0, 0, 0, 0); tick();
    set_req(0, 1, 32'd1, 32'd1, 5'd3);
    set_req(1, 1, 32'd1, 32'd1, 5'd4);
    #2;
    grst = 1'b1;
    #1;
    chk("arst_rdy0", bus.req0_rdy, 1'b0);
    chk("arst_rdy1", bus.req1_rdy, 1'b0);
    chk("arst_res0", bus.res0_vld, 1'b0);
    chk("arst_res1", bus.res1_vld, 1'b0);
    chk("arst_opa", bus.mul_opa, 32'd0);
    inflight.delete();
    prio = 0;
    @(negedge gclk);
    grst = 1'b0;
    #1;
    chk("post_rst_rdy0", bus.req0_rdy, 1'b1);
    #1;
    tick();
    idle();
    repeat (3) tick();

    // back-to-back single requester
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1, 32'd100 + i, 32'd1000 + i, 5'(i + 20));
      tick();
    end
    idle();
    repeat (3) tick();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      bus.dena   = ($urandom_range(0, 9) < 8);
      bus.flush0 = ($urandom_range(0, 15) == 0);
      bus.flush1 = ($urandom_range(0, 15) == 0);
      set_req(0, $urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom));
      set_req(1, $urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom));
      tick();
    end
    idle();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
